hex_word_pack: RTL and testbench

Assembles the 4-bit hex nibble stream from the ASCII-to-hex converter into fixed-width words for the SDRAM command/data path. Sits directly downstream of the ASCII-to-hex stage in the UART receive chain. Presents each completed word through a single-entry valid/ready output buffer. Discards partial words after an inactivity timeout and flags words lost to back-pressure.

---
 rtl/hex_word_pack.sv | 134 +++++++++++++
 tb/tb_hex_word_pack.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_pack.sv
// hex_word_pack: packs a stream of hex nibbles into DOUT_W-bit words.
// The first nibble of a word becomes its most significant nibble. Each
// completed word goes into a single-entry valid/ready output buffer. A word
// that completes while the buffer is occupied and not draining is dropped
// and err_ovf pulses. A partial word that sees no new nibble for TMO_CYC
// cycles is discarded and err_tmo pulses.
module hex_word_pack #(
    parameter int unsigned DIN_W   = 4,
    parameter int unsigned NIB_NUM = 8,
    parameter int unsigned DOUT_W  = DIN_W * NIB_NUM,
    parameter int unsigned TMO_CYC = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_vld,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              busy,
    output logic              err_ovf,
    output logic              err_tmo
);

    localparam int unsigned CNT_W = (NIB_NUM > 1) ? $clog2(NIB_NUM) : 1;
    localparam int unsigned IDL_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(NIB_NUM - 1);
    localparam logic [IDL_W-1:0] IdlLast = IDL_W'(TMO_CYC - 1);

    // Architectural state
    logic [DOUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDL_W-1:0]  idl_q, idl_d;
    logic [DOUT_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              busy_q, busy_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_tmo_q, err_tmo_d;

    // Decoded conditions for the current cycle
    logic [DOUT_W-1:0] word;
    logic              cnt_zero;
    logic              complete;
    logic              buf_free;
    logic              handshake;
    logic              expire;

    // Decode completion, buffer availability and timeout expiry.
    always_comb begin
        word      = {acc_q[DOUT_W-DIN_W-1:0], din};
        cnt_zero  = (cnt_q == '0);
        complete  = din_vld && (cnt_q == CntLast);
        handshake = dout_vld_q && dout_rdy;
        buf_free  = !dout_vld_q || dout_rdy;
        // A nibble in the expiry cycle wins over the timeout.
        expire    = !din_vld && !cnt_zero && (idl_q == IdlLast);
    end

    // Next state of the accumulator, nibble counter and idle counter.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        idl_d = idl_q;

        if (din_vld) begin
            acc_d = word;
            cnt_d = complete ? '0 : cnt_q + CNT_W'(1);
        end else if (expire) begin
            // acc keeps stale nibbles; they are shifted out by the next word.
            cnt_d = '0;
        end

        if (din_vld || cnt_zero || expire) begin
            idl_d = '0;
        end else begin
            idl_d = idl_q + IDL_W'(1);
        end
    end

    // Next state of the output buffer and the status/error flags.
    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        err_ovf_d  = 1'b0;
        err_tmo_d  = expire;

        if (complete && buf_free) begin
            // Covers both an empty buffer and a same-cycle drain-and-refill.
            dout_d     = word;
            dout_vld_d = 1'b1;
        end else begin
            if (complete) begin
                // Buffer busy and not draining: keep the held word.
                err_ovf_d = 1'b1;
            end
            if (handshake) begin
                dout_vld_d = 1'b0;
            end
        end

        busy_d = (cnt_d != '0);
    end

    // State update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            idl_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            idl_q      <= idl_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            busy_q     <= busy_d;
            err_ovf_q  <= err_ovf_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign busy     = busy_q;
    assign err_ovf  = err_ovf_q;
    assign err_tmo  = err_tmo_q;

endmodule

// File: tb/tb_hex_word_pack.sv
// Scoreboard bench for hex_word_pack: a nibble-queue reference model predicts
// per-cycle status and the words expected at each output handshake.
module tb_hex_word_pack;

    localparam int unsigned NIB = 8;
    localparam int unsigned TMO = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  din;
    logic        din_vld;
    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_rdy;
    logic        busy;
    logic        err_ovf;
    logic        err_tmo;

    hex_word_pack #(
        .DIN_W  (4),
        .NIB_NUM(NIB),
        .DOUT_W (32),
        .TMO_CYC(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .dout    (dout),
        .dout_vld(dout_vld),
        .dout_rdy(dout_rdy),
        .busy    (busy),
        .err_ovf (err_ovf),
        .err_tmo (err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic        bsy;
        logic        ovf;
        logic        tmo;
        logic        chk_dout;
        logic [31:0] dout;
    } exp_t;

    exp_t        flag_q[$];
    logic [31:0] word_q[$];

    // Reference model state
    logic [3:0]  nibs[$];
    int          idle;
    bit          mvld;
    logic [31:0] mword;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endfunction

    // Advance the model by one clock edge with the given inputs.
    function automatic void apply(bit v, logic [3:0] d, bit r, bit rs);
        exp_t        e;
        logic [31:0] w;
        bit          loaded;
        bit          hs;
        din_vld  = v;
        din      = d;
        dout_rdy = r;
        rst      = rs;
        e        = '0;
        if (rs) begin
            nibs.delete();
            word_q.delete();
            idle       = 0;
            mvld       = 0;
            mword      = '0;
            e.chk_dout = 1'b1;
            e.dout     = '0;
            flag_q.push_back(e);
            return;
        end
        loaded = 0;
        hs     = mvld && r;
        if (v) begin
            nibs.push_back(d);
            idle = 0;
            if (nibs.size() == NIB) begin
                w = '0;
                foreach (nibs[i]) w = {w[27:0], nibs[i]};
                nibs.delete();
                if (!mvld || r) begin
                    loaded = 1;
                    mvld   = 1;
                    mword  = w;
                    word_q.push_back(w);
                end else begin
                    e.ovf = 1'b1;
                end
            end
        end else if (nibs.size() != 0) begin
            idle++;
            if (idle == TMO) begin
                e.tmo = 1'b1;
                nibs.delete();
                idle = 0;
            end
        end
        if (hs && !loaded) mvld = 0;
        e.vld      = mvld;
        e.bsy      = (nibs.size() != 0);
        e.chk_dout = mvld;
        e.dout     = mword;
        flag_q.push_back(e);
    endfunction

    task automatic step(input bit v, input logic [3:0] d, input bit r, input bit rs);
        @(negedge clk);
        apply(v, d, r, rs);
    endtask

    task automatic idle_for(input int n, input bit r);
        for (int i = 0; i < n; i++) step(0, 4'h0, r, 0);
    endtask

    // Send one word MSB nibble first, with up to gap_max idle cycles between nibbles.
    task automatic send_word(input logic [31:0] w, input int gap_max, input bit r);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 0; i < NIB; i++) begin
            if (i != 0 && gap_max > 0) idle_for($urandom_range(0, gap_max), r);
            step(1, tmp[31:28], r, 0);
            tmp = {tmp[27:0], 4'h0};
        end
    endtask

    // Monitor: per-cycle status checks and handshake-driven word checks.
    initial begin
        exp_t        e;
        logic        prev_vld;
        logic [31:0] prev_dout;
        logic [31:0] w;
        prev_vld  = 1'b0;
        prev_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && prev_vld && dout_rdy) begin
                if (word_q.size() == 0) begin
                    chk("unexpected_handshake", 32'd1, 32'd0);
                end else begin
                    w = word_q.pop_front();
                    chk("hs_word", prev_dout, w);
                end
            end
            if (flag_q.size() != 0) begin
                e = flag_q.pop_front();
                chk("dout_vld", {31'd0, dout_vld}, {31'd0, e.vld});
                chk("busy", {31'd0, busy}, {31'd0, e.bsy});
                chk("err_ovf", {31'd0, err_ovf}, {31'd0, e.ovf});
                chk("err_tmo", {31'd0, err_tmo}, {31'd0, e.tmo});
                if (e.chk_dout) chk("dout", dout, e.dout);
            end
            prev_vld  = dout_vld;
            prev_dout = dout;
        end
    end

    // Stimulus
    initial begin
        int pv;
        int pr;
        idle  = 0;
        mvld  = 0;
        mword = '0;
        apply(0, 4'h0, 0, 1);
        step(0, 4'h0, 0, 1);

        // Basic word, consumer always ready
        send_word(32'h1234ABCD, 0, 1);
        idle_for(4, 1);

        // Gapped input, then 20 stalled cycles before release
        send_word(32'h01234567, 3, 0);
        idle_for(20, 0);
        idle_for(3, 1);

        // Overflow: second word dropped while the first is held
        send_word(32'h11111111, 0, 0);
        send_word(32'h22222222, 0, 0);
        idle_for(3, 0);
        idle_for(2, 1);

        // Same, but ready in the completion cycle: second word loads cleanly
        send_word(32'h11111111, 0, 0);
        for (int i = 0; i < NIB - 1; i++) step(1, 4'h2, 0, 0);
        step(1, 4'h2, 1, 0);
        idle_for(3, 1);

        // Timeout of a 3-nibble partial word, then a full word
        for (int i = 0; i < 3; i++) step(1, 4'(i + 5), 1, 0);
        idle_for(TMO + 3, 1);
        send_word(32'hFEDCBA98, 0, 1);
        idle_for(2, 1);

        // Nibble exactly at the expiry cycle keeps the partial word alive
        for (int i = 0; i < 3; i++) step(1, 4'(i + 1), 1, 0);
        idle_for(TMO - 1, 1);
        for (int i = 0; i < 5; i++) step(1, 4'(i + 4), 1, 0);
        idle_for(3, 1);

        // Reset mid-word and while a word is held
        for (int i = 0; i < 5; i++) step(1, 4'hE, 1, 0);
        step(0, 4'h0, 1, 1);
        send_word(32'hCAFE0123, 0, 0);
        idle_for(3, 0);
        step(0, 4'h0, 0, 1);
        send_word(32'h89ABCDEF, 0, 1);
        idle_for(3, 1);

        // Randomized traffic with varying input density and back-pressure
        pv = 90;
        pr = 100;
        for (int c = 0; c < 6000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: pv = 95;
                    1: pv = 50;
                    default: pv = 6;
                endcase
                case ($urandom_range(0, 2))
                    0: pr = 100;
                    1: pr = 60;
                    default: pr = 10;
                endcase
            end
            step($urandom_range(0, 99) < pv, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < pr, $urandom_range(0, 699) == 0);
        end

        // Drain and confirm every predicted word was handed over
        idle_for(TMO + 4, 1);
        @(posedge clk);
        #2;
        chk("words_left", 32'(word_q.size()), 32'd0);
        chk("status_left", 32'(flag_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
